// File: rtl/sm_timer_pkg.sv
// Shared types for the memory-mapped timer: register select and CTRL layout.
// No logic of its own; helpers are pure combinational conversions.
// Not applicable to flow control.
`include "sm_settings.vh"

package sm_timer_pkg;

    typedef enum logic [1:0] {
        REG_CTRL    = `TMR_CTRL,
        REG_COUNT   = `TMR_COUNT,
        REG_COMPARE = `TMR_COMPARE,
        REG_STATUS  = `TMR_STATUS
    } tmr_reg_e;

    typedef struct packed {
        logic arl;
        logic ie;
        logic en;
    } tmr_ctrl_t;

    // Pick the architected CTRL bits out of the low bits of a bus write
    function automatic tmr_ctrl_t ctrl_from_bits(input logic [2:0] w);
        tmr_ctrl_t c;
        c.en  = w[`TMR_CTRL_EN];
        c.ie  = w[`TMR_CTRL_IE];
        c.arl = w[`TMR_CTRL_ARL];
        return c;
    endfunction

    // Place CTRL fields at their architected positions, unused bits read 0
    function automatic logic [31:0] ctrl_to_word(input tmr_ctrl_t c);
        logic [31:0] w;
        w = '0;
        w[`TMR_CTRL_EN]  = c.en;
        w[`TMR_CTRL_IE]  = c.ie;
        w[`TMR_CTRL_ARL] = c.arl;
        return w;
    endfunction

endpackage

// File: rtl/sm_settings.vh
`ifndef SM_SETTINGS_VH
`define SM_SETTINGS_VH

// Timer register word offsets (bsAddr[3:2])
`define TMR_CTRL         2'd0
`define TMR_COUNT        2'd1
`define TMR_COMPARE      2'd2
`define TMR_STATUS       2'd3

// CTRL bit positions
`define TMR_CTRL_EN      0
`define TMR_CTRL_IE      1
`define TMR_CTRL_ARL     2

// STATUS bit positions
`define TMR_STATUS_MATCH 0

`endif

// File: rtl/sm_timer_presc.sv
// Prescaler: divides the enabled clock into a one-cycle tick every DIV cycles.
// Tick is combinational from the phase register (asserted in the last phase).
// No backpressure; clr forces phase 0 and overrides counting.
module sm_timer_presc #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_phase;

    // Phase counter: 0..DIV-1 while enabled, frozen when disabled, cleared on clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (en) begin
            r_phase <= (r_phase == LAST) ? '0 : r_phase + 1'b1;
        end
    end

    assign tick = en && (r_phase == LAST);

endmodule

// File: rtl/sm_timer.sv
// Memory-mapped timer/compare peripheral: prescaled counter, compare match flag, auto-reload, level IRQ.
// Reads combinational in the access cycle; writes commit on the clk edge; MATCH/irq one cycle after tick.
// Never stalls the bus: no wait states, every access completes in its own cycle.
`include "sm_settings.vh"

module sm_timer
    import sm_timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int PRESC_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bsSel,
    input  logic [31:0] bsAddr,
    input  logic        bsWe,
    input  logic [31:0] bsWData,
    output logic [31:0] bsRData,
    output logic        irq
);

    tmr_ctrl_t        r_ctrl;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_compare;
    logic             r_match;

    tmr_reg_e         w_reg;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_compare;
    logic             w_wr_status;
    logic             w_tick;
    logic             w_hit;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_unused;

    // Only the word offset is decoded; the rest of the address is don't-care
    assign w_unused = &{1'b0, bsAddr[31:4], bsAddr[1:0]};

    assign w_reg        = tmr_reg_e'(bsAddr[3:2]);
    assign w_wr         = bsSel & bsWe;
    assign w_wr_ctrl    = w_wr && (w_reg == REG_CTRL);
    assign w_wr_count   = w_wr && (w_reg == REG_COUNT);
    assign w_wr_compare = w_wr && (w_reg == REG_COMPARE);
    assign w_wr_status  = w_wr && (w_reg == REG_STATUS);

    // A COUNT write restarts the prescaler so the first period after a reload is full length
    sm_timer_presc #(
        .DIV (PRESC_DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_ctrl.en),
        .clr   (w_wr_count),
        .tick  (w_tick)
    );

    // Match compares the pre-increment count against the compare value held before any same-cycle write
    assign w_hit       = w_tick && (r_count == r_compare);
    assign w_count_inc = r_count + 1'b1;

    // CTRL register; a write clearing EN still lets this cycle's tick land because tick uses the old EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl <= '0;
        end else if (w_wr_ctrl) begin
            r_ctrl <= ctrl_from_bits(bsWData[2:0]);
        end
    end

    // COUNT: bus write beats the tick; otherwise advance, reloading to 0 on an auto-reload match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= bsWData[WIDTH-1:0];
        end else if (w_tick) begin
            r_count <= (w_hit && r_ctrl.arl) ? '0 : w_count_inc;
        end
    end

    // COMPARE register, resets to all ones so an unconfigured timer matches as late as possible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_compare <= '1;
        end else if (w_wr_compare) begin
            r_compare <= bsWData[WIDTH-1:0];
        end
    end

    // MATCH flag: a new match outranks a same-cycle write-1-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status && bsWData[`TMR_STATUS_MATCH]) begin
            r_match <= 1'b0;
        end
    end

    // Read mux: zero-extended register contents, independent of bsSel
    always_comb begin
        bsRData = '0;
        case (w_reg)
            REG_CTRL:    bsRData = ctrl_to_word(r_ctrl);
            REG_COUNT:   bsRData[WIDTH-1:0] = r_count;
            REG_COMPARE: bsRData[WIDTH-1:0] = r_compare;
            REG_STATUS:  bsRData[`TMR_STATUS_MATCH] = r_match;
            default:     bsRData = '0;
        endcase
    end

    assign irq = r_match & r_ctrl.ie;

endmodule
